shift_normalizer: RTL and testbench
===================================

# shift_normalizer

Sequential normalizer: the inverse of the team's combinational left/right shifter. Given a value, it recovers the shift that produced it. It shifts the operand one bit per cycle until the target end bit is 1, then reports the normalized value and the shift count. Shifting the normalized `out` back by `amount` in the opposite direction reproduces `A`. It sits beside the shifter in the VBSME datapath and exposes a start/busy/done handshake to the controlling FSM.

## Interface
- `WIDTH`, default 5: operand width.
- `CNT_W`, default 3: width of `amount`. Must satisfy 2^CNT_W > WIDTH-1.
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Rst` in 1: reset, synchronous and active-high.
- `start` in 1: request; sampled only in IDLE.
- `sel` in 1: direction. 0 = normalize left (shift left until MSB = 1). 1 = normalize right (shift right until LSB = 1). Same encoding as the shifter.
- `A` in WIDTH: operand; sampled with `start`.
- `busy` out 1: high in SHIFT and DONE states.
- `done` out 1: one-cycle pulse; results valid.
- `out` out WIDTH: normalized value.
- `amount` out CNT_W: number of single-bit shifts applied.
- `zero` out 1: `A` was 0; normalization undefined.

## Operation
- States: IDLE, SHIFT, DONE. State register, `out`, `amount` and `zero` are all registered.
- **IDLE**, `start`=1:
  - Latch `sel` internally.
  - Load `out`=`A`, `amount`=0.
  - If `A`==0: `zero`=1, next state DONE.
  - Otherwise: `zero`=0, next state SHIFT.
- **IDLE**, `start`=0: hold all registers.
- **SHIFT**:
  - Target bit is `out[WIDTH-1]` when the latched sel=0, `out[0]` when sel=1.
  - If the target bit is 1: next state DONE; `out` and `amount` hold.
  - Otherwise: `out` shifts logically by 1 (zero fill) in the latched direction, `amount` += 1, stay in SHIFT.
  - Nonzero input guarantees termination with `amount` ≤ WIDTH-1. No wrap of `amount` is possible.
- **DONE**: `done`=1 for exactly this cycle; next state IDLE unconditionally.
- `out`, `amount` and `zero` hold their final values after DONE until the next accepted `start`. During SHIFT they show intermediate values and are not valid.
- `start` is ignored while `busy`=1, including the DONE cycle. `A` and `sel` changes while busy have no effect.
- Round-trip property (nonzero `A`):
  - sel=0: `out >> amount` == `A`.
  - sel=1: `out << amount` == `A` (truncated to WIDTH).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `out`=0, `amount`=0, `zero`=0.
- `Rst` wins over all other inputs in any state. It aborts an operation in progress on the next edge with no `done` pulse.
- `start` accepted at edge of cycle t. With shift count k:
  - Nonzero `A`: `busy` high from t+1; `done` high in cycle t+2+k. Worst case is t+WIDTH+1.
  - `A`==0: `done` high in cycle t+1.
- Back-to-back operation: `start` in the cycle after `done` (state IDLE) is accepted. Minimum issue interval is 2 cycles for zero, k+3 otherwise.
- Latched `sel` is used for the whole operation; mid-operation `sel` changes are ignored.

## Test plan
- Reset: hold `Rst` 2 cycles with `start`=1 and `A`=5'b00011 -> `busy`=0, `done`=0, `out`=0, `amount`=0, `zero`=0 throughout; no operation starts.
- Left normalize: sel=0, `A`=5'b00011, `start` at t -> `done` only in cycle t+5, `out`=5'b11000, `amount`=3, `zero`=0; `out>>amount` == `A`.
- Right normalize: sel=1, `A`=5'b10100 at t -> `done` in cycle t+4, `out`=5'b00101, `amount`=2; `out<<amount` == `A`.
- Zero and already-normalized cases:
  - `A`=0 -> `done` at t+1, `zero`=1, `out`=0, `amount`=0.
  - sel=0, `A`=5'b10000 -> `done` at t+2, `amount`=0.
  - sel=1, `A`=5'b00001 -> `done` at t+2, `amount`=0.
- Handshake:
  - Pulse `start` with `A`=5'b00001, sel=0; hold `start` high with different `A` and `sel` for every busy cycle -> single result `out`=5'b10000, `amount`=4 at t+6.
  - Second `start` in the cycle after `done` is accepted.
- Abort: sel=0, `A`=5'b00001; assert `Rst` in cycle t+3 -> next cycle `busy`=0, `out`=0, `amount`=0, and no `done` pulse ever appears for that operation.

Source files
------------

// File: rtl/shift_normalizer.sv
// shift_normalizer: sequential normalizer, the inverse of the left/right shifter.
// Ports: Clk, Rst (sync, active-high), start/sel/A in; busy/done/out/amount/zero out.
module shift_normalizer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] amount,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state;
  state_t nstate;
  logic   dir;
  logic   target;

  // dir is the direction latched at start; live sel is ignored
  // for the remainder of the operation.
  assign target = dir ? out[0] : out[WIDTH-1];

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (start) nstate = (A == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (target) nstate = S_DONE;
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out    <= '0;
      amount <= '0;
      zero   <= 1'b0;
      dir    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dir    <= sel;
            out    <= A;
            amount <= '0;
            zero   <= (A == '0);
          end
        end
        S_SHIFT: begin
          // Nonzero operand guarantees target is reached before
          // amount can exceed WIDTH-1, so no wrap handling.
          if (!target) begin
            out    <= dir ? (out >> 1) : (out << 1);
            amount <= amount + ONE;
          end
        end
        default: begin
          out    <= out;
          amount <= amount;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and randomized checks of shift_normalizer
// against a bit-position reference model.
module tb_shift_normalizer;

  localparam int W  = 5;
  localparam int CW = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic          sel;
  logic [W-1:0]  A;
  logic          busy;
  logic          done;
  logic [W-1:0]  out;
  logic [CW-1:0] amount;
  logic          zero;

  int ncmp = 0;
  int nerr = 0;

  shift_normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .sel    (sel),
    .A      (A),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .amount (amount),
    .zero   (zero)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of highest / lowest set bit of a nonzero operand.
  function automatic int hi_bit(input logic [W-1:0] a);
    int h = 0;
    for (int i = 0; i < W; i++) if (a[i]) h = i;
    return h;
  endfunction

  function automatic int lo_bit(input logic [W-1:0] a);
    int l = 0;
    for (int i = W - 1; i >= 0; i--) if (a[i]) l = i;
    return l;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic s,
                        input bit hold);
    int           k;
    int           lat;
    logic [W-1:0] eo;
    logic [W-1:0] rt;
    if (a == '0) begin
      k = 0; lat = 1; eo = '0;
    end else if (s == 1'b0) begin
      k = W - 1 - hi_bit(a); lat = 2 + k; eo = a << k;
    end else begin
      k = lo_bit(a); lat = 2 + k; eo = a >> k;
    end
    start = 1'b1; A = a; sel = s;
    step();
    for (int c = 1; c <= lat; c++) begin
      chk("busy", 32'(busy), 32'(1));
      chk("done", 32'(done), 32'(c == lat));
      if (c == lat) begin
        chk("out",    32'(out),    32'(eo));
        chk("amount", 32'(amount), 32'(k));
        chk("zero",   32'(zero),   32'(a == '0));
        if (a != '0) begin
          rt = s ? (out << amount) : (out >> amount);
          chk("roundtrip", 32'(rt), 32'(a));
        end
      end
      start = hold;
      A     = W'($urandom);
      sel   = 1'($urandom);
      step();
    end
    start = 1'b0;
    chk("idle_busy", 32'(busy),   32'(0));
    chk("idle_done", 32'(done),   32'(0));
    chk("hold_out",  32'(out),    32'(eo));
    chk("hold_amt",  32'(amount), 32'(k));
  endtask

  initial begin
    Rst = 1'b1; start = 1'b1; A = 5'b00011; sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_busy", 32'(busy),   32'(0));
      chk("rst_done", 32'(done),   32'(0));
      chk("rst_out",  32'(out),    32'(0));
      chk("rst_amt",  32'(amount), 32'(0));
      chk("rst_zero", 32'(zero),   32'(0));
    end
    Rst = 1'b0; start = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'(0));

    run_op(5'b00011, 1'b0, 1'b0);
    run_op(5'b10100, 1'b1, 1'b0);
    run_op(5'b00000, 1'b0, 1'b0);
    run_op(5'b10000, 1'b0, 1'b0);
    run_op(5'b00001, 1'b1, 1'b0);
    run_op(5'b00001, 1'b0, 1'b1);
    run_op(5'b00110, 1'b1, 1'b1);
    step();

    // Abort: reset in cycle t+3 kills the operation.
    start = 1'b1; A = 5'b00001; sel = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    Rst = 1'b1;
    step();
    chk("abort_busy", 32'(busy),   32'(0));
    chk("abort_out",  32'(out),    32'(0));
    chk("abort_amt",  32'(amount), 32'(0));
    chk("abort_done", 32'(done),   32'(0));
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_nodone", 32'(done), 32'(0));
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(ra, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
